// File: rtl/sw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_pkg : shared constants for the switch debounce front end          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sw_pkg;

    localparam int SW_DATA_W         = 8;
    localparam int SW_CLK_DIV        = 50000;
    localparam int SW_STABLE_CNT     = 4;
    localparam int SW_SIM_CLK_DIV    = 4;
    localparam int SW_SIM_STABLE_CNT = 3;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int sw_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_bit : 2-flop synchroniser plus tick-sampled stability count |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module debounce_bit
    import sw_pkg::*;
#(
    parameter int STABLE_CNT = SW_STABLE_CNT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_toggle
);

    localparam int              CNT_W     = sw_cnt_w(STABLE_CNT);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_at_max;

    assign w_diff   = r_sync2 ^ r_level;
    assign w_at_max = (r_cnt == c_CNT_MAX);
    assign o_toggle = i_tick & w_diff & w_at_max;
    assign o_level  = r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample matching the current level restarts qualification.
            if (i_tick) begin
                if (!w_diff) begin
                    r_cnt <= '0;
                end else if (w_at_max) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_debounce : debounced code/enable switches with change strobe      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sw_debounce
    import sw_pkg::*;
#(
    parameter int DATA_W     = SW_DATA_W,
    parameter int CLK_DIV    = SW_CLK_DIV,
    parameter int STABLE_CNT = SW_STABLE_CNT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_sw,
    input  logic              i_sw_en,
    output logic [DATA_W-1:0] o_code,
    output logic              o_en,
    output logic              o_change
);

    localparam int               DIV_W     = sw_cnt_w(CLK_DIV);
    localparam logic [DIV_W-1:0] c_DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_change;
    logic             w_tick;
    logic [DATA_W:0]  w_raw;
    logic [DATA_W:0]  w_level;
    logic [DATA_W:0]  w_toggle;

    assign w_tick = (r_div == c_DIV_MAX);
    assign w_raw  = {i_sw_en, i_sw};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi <= DATA_W; gi++) begin : g_bit
            debounce_bit #(
                .STABLE_CNT (STABLE_CNT)
            ) u_bit (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_tick   (w_tick),
                .i_raw    (w_raw[gi]),
                .o_level  (w_level[gi]),
                .o_toggle (w_toggle[gi])
            );
        end
    endgenerate

    // Registered so the strobe lines up with the first cycle of the new level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_change <= 1'b0;
        end else begin
            r_change <= |w_toggle;
        end
    end

    assign o_code   = w_level[DATA_W-1:0];
    assign o_en     = w_level[DATA_W];
    assign o_change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sw_debounce : scoreboard bench for sw_debounce (CLK_DIV=4, SC=3)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sw_debounce;
    import sw_pkg::*;

    typedef struct {
        logic [8:0] val;
        int         lo;
        int         hi;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic       sw_en;
    logic [7:0] o_code;
    logic       o_en;
    logic       o_change;

    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t q[$];
    logic [8:0] prev_out;
    logic       prev_chg;

    sw_debounce #(
        .DATA_W     (SW_DATA_W),
        .CLK_DIV    (SW_SIM_CLK_DIV),
        .STABLE_CNT (SW_SIM_STABLE_CNT)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sw     (sw),
        .i_sw_en  (sw_en),
        .o_code   (o_code),
        .o_en     (o_en),
        .o_change (o_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe pops one expectation; no output may move without one.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_out = {o_en, o_code};
            prev_chg = 1'b0;
        end else begin
            if (o_change) begin
                n_tests++;
                if (prev_chg) begin
                    n_fail++;
                    $display("FAIL change_back2back: o_change high two cycles in a row at cyc %0d", cyc);
                end
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: pulse at cyc %0d with out=%h, none expected", cyc, {o_en, o_code});
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ({o_en, o_code} !== e.val) begin
                        n_fail++;
                        $display("FAIL change_value: got %h, expected %h", {o_en, o_code}, e.val);
                    end
                    n_tests++;
                    if (cyc < e.lo || cyc > e.hi) begin
                        n_fail++;
                        $display("FAIL change_latency: pulse at cyc %0d, expected %0d..%0d", cyc, e.lo, e.hi);
                    end
                end
            end else begin
                n_tests++;
                if ({o_en, o_code} !== prev_out) begin
                    n_fail++;
                    $display("FAIL silent_change: out %h -> %h without o_change at cyc %0d", prev_out, {o_en, o_code}, cyc);
                end
            end
            prev_out = {o_en, o_code};
            prev_chg = o_change;
        end
    end

    task automatic apply(input logic [7:0] v, input logic en, input bit push, input int lo, input int hi);
        @(posedge clk);
        #1;
        sw    = v;
        sw_en = en;
        if (push) q.push_back('{{en, v}, cyc + lo, cyc + hi});
    endtask

    task automatic drain(input string name, input int idle);
        int b;
        b = 0;
        while (q.size() != 0 && b < 40) begin
            @(posedge clk);
            b++;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d expected changes never seen, need 0", name, q.size());
            q.delete();
        end
        repeat (idle) @(posedge clk);
    endtask

    task automatic check_out(input string name, input logic [8:0] exp_v, input logic exp_c);
        n_tests++;
        if ({o_en, o_code} !== exp_v || o_change !== exp_c) begin
            n_fail++;
            $display("FAIL %s: out=%h chg=%b, expected out=%h chg=%b", name, {o_en, o_code}, o_change, exp_v, exp_c);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        prev_out = '0;
        prev_chg = 1'b0;

        // Reset held with all switches high: outputs stay cleared.
        rst_n = 1'b0;
        sw    = 8'hFF;
        sw_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_out("reset_hold", 9'h000, 1'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.push_back('{9'h1FF, cyc + 11, cyc + 14});
        drain("reset_release", 4);

        // Clean steps.
        apply(8'h00, 1'b0, 1'b1, 11, 14);
        drain("clear", 4);
        apply(8'h80, 1'b1, 1'b1, 11, 14);
        drain("clean_step", 16);
        check_out("clean_step_level", 9'h180, 1'b0);

        // Bounce on bit 3 (period 6 < 12), then settle high.
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            sw[3] = ~sw[3];
            repeat (2) @(posedge clk);
        end
        apply(8'h88, 1'b1, 1'b1, 1, 14);
        drain("bounce", 16);
        check_out("bounce_level", 9'h188, 1'b0);

        // Short glitch on bit 0.
        apply(8'h89, 1'b1, 1'b0, 0, 0);
        repeat (5) @(posedge clk);
        apply(8'h88, 1'b1, 1'b0, 0, 0);
        repeat (24) @(posedge clk);
        #1;
        check_out("glitch_level", 9'h188, 1'b0);

        // Simultaneous multi-bit edits.
        apply(8'h0F, 1'b1, 1'b1, 11, 14);
        drain("multi_0f", 4);
        apply(8'hF0, 1'b1, 1'b1, 11, 14);
        drain("multi_f0", 16);
        check_out("multi_level", 9'h1F0, 1'b0);

        // Asynchronous reset in the middle of qualifying a new value.
        apply(8'h01, 1'b1, 1'b0, 0, 0);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_out("async_reset_drop", 9'h000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.push_back('{9'h101, cyc + 11, cyc + 14});
        drain("post_reset", 16);
        check_out("post_reset_level", 9'h101, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
